// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the I/D memory port arbiter.
// Requester tags, arbiter states and the read-tag slot format live here.
package mem_arb_pkg;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        requester_t owner;
    } rd_tag_t;

    localparam int unsigned RD_LAT_MAX = 8;
    localparam int unsigned LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, owner} tags for in-flight reads.
// A slot is pushed every cycle; the head lines up with the memory's m_rvalid.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    input  logic push_owner,
    output logic head_valid,
    output logic head_owner
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= '{valid: push_valid, owner: requester_t'(push_owner)};
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign head_valid = stage[DEPTH-1].valid;
    assign head_owner = stage[DEPTH-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch (I) and data (D) ports onto one single-port memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on contention instead of D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              protocol_err
);

    arb_state_t           state;
    requester_t           sel;
    logic                 sel_valid;
    logic                 both_pick_d;
    logic                 is_d;
    logic                 issue;
    logic                 ret;
    logic                 head_valid;
    logic                 head_owner;
    logic [LAT_CNT_W-1:0] drain;

`ifdef ARB_ROUND_ROBIN_EN
    requester_t last_owner;
    assign both_pick_d = (last_owner == REQ_I);
`else
    assign both_pick_d = 1'b1;
`endif

    always_comb begin
        sel_valid = 1'b0;
        sel       = REQ_I;
        case (state)
            ARB_HOLD_I: begin
                sel_valid = i_req;
                sel       = REQ_I;
            end
            ARB_HOLD_D: begin
                sel_valid = d_req;
                sel       = REQ_D;
            end
            default: begin
                if (i_req && d_req) begin
                    sel_valid = 1'b1;
                    sel       = both_pick_d ? REQ_D : REQ_I;
                end else if (d_req) begin
                    sel_valid = 1'b1;
                    sel       = REQ_D;
                end else if (i_req) begin
                    sel_valid = 1'b1;
                    sel       = REQ_I;
                end
            end
        endcase
    end

    assign is_d    = (sel == REQ_D);
    assign m_req   = !rst && sel_valid;
    assign m_we    = m_req && is_d && d_we;
    assign m_addr  = !m_req ? '0 : (is_d ? d_addr : i_addr);
    assign m_wdata = (m_req && is_d) ? d_wdata : '0;
    assign issue   = m_req && m_gnt;
    assign i_gnt   = issue && !is_d;
    assign d_gnt   = issue && is_d;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue && !m_we),
        .push_owner (sel),
        .head_valid (head_valid),
        .head_owner (head_owner)
    );

    // Only a tagged head slot routes data back; stray m_rvalid is dropped.
    assign ret      = !rst && head_valid && m_rvalid;
    assign i_rvalid = ret && (head_owner == REQ_I);
    assign d_rvalid = ret && (head_owner == REQ_D);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

    // drain masks m_rvalid for reads that were in flight when reset hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            protocol_err <= 1'b0;
            drain        <= LAT_CNT_W'(RD_LAT);
`ifdef ARB_ROUND_ROBIN_EN
            last_owner   <= REQ_I;
`endif
        end else begin
            if (drain != '0) begin
                drain <= drain - LAT_CNT_W'(1);
            end
            case (state)
                ARB_IDLE: begin
                    if (m_req && !m_gnt) begin
                        state <= is_d ? ARB_HOLD_D : ARB_HOLD_I;
                    end
                end
                ARB_HOLD_I, ARB_HOLD_D: begin
                    if (!sel_valid) begin
                        state        <= ARB_IDLE;
                        protocol_err <= 1'b1;
                    end else if (m_gnt) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
            if ((m_rvalid && !head_valid && drain == '0) || (head_valid && !m_rvalid)) begin
                protocol_err <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (issue) begin
                last_owner <= sel;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u_dut runs with RD_LAT=1, u_dut3 with RD_LAT=3.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        protocol_err;

    logic        l3_i_req, l3_i_gnt, l3_i_rvalid;
    logic [31:0] l3_i_addr, l3_i_rdata;
    logic        l3_d_req, l3_d_we, l3_d_gnt, l3_d_rvalid;
    logic [31:0] l3_d_addr, l3_d_wdata, l3_d_rdata;
    logic        l3_m_req, l3_m_we, l3_m_gnt, l3_m_rvalid;
    logic [31:0] l3_m_addr, l3_m_wdata, l3_m_rdata;
    logic        l3_protocol_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .protocol_err(protocol_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(l3_i_req), .i_addr(l3_i_addr), .i_gnt(l3_i_gnt), .i_rvalid(l3_i_rvalid), .i_rdata(l3_i_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
        .m_req(l3_m_req), .m_we(l3_m_we), .m_addr(l3_m_addr), .m_wdata(l3_m_wdata),
        .m_gnt(l3_m_gnt), .m_rvalid(l3_m_rvalid), .m_rdata(l3_m_rdata),
        .protocol_err(l3_protocol_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        l3_i_req = 0; l3_i_addr = '0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = '0; l3_d_wdata = '0;
        l3_m_gnt = 0; l3_m_rvalid = 0; l3_m_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234;
        m_gnt = 1; m_rvalid = 1; m_rdata = 32'h5A5A;
        #2;
        checks++;
        if ({m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, protocol_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, protocol_err});
        end
        checks++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {m_addr, m_wdata, i_rdata, d_rdata});
        end
        checks++;
        if (u_dut.state !== ARB_IDLE || l3_protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d err3=%b expected state=0 err3=0",
                     u_dut.state, l3_protocol_err);
        end
        idle_inputs();
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_dual_read();
        // cycle 0: both request, D wins
        i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20; m_gnt = 1;
        #2;
        checks++;
        if ({d_gnt, i_gnt, m_we, m_addr} !== {3'b100, 32'h20}) begin
            errors++;
            $display("FAIL dual_c0: got gnt_d/i/we=%b addr=%h expected 100 addr=00000020",
                     {d_gnt, i_gnt, m_we}, m_addr);
        end
        tick();
        // cycle 1: I granted, D read data returns
        d_req = 0; m_rvalid = 1; m_rdata = 32'hAAAA;
        #2;
        checks++;
        if ({i_gnt, d_gnt, m_addr, m_wdata} !== {2'b10, 32'h10, 32'h0}) begin
            errors++;
            $display("FAIL dual_c1_gnt: got gnt_i/d=%b addr=%h wdata=%h expected 10 00000010 00000000",
                     {i_gnt, d_gnt}, m_addr, m_wdata);
        end
        checks++;
        if ({d_rvalid, i_rvalid, d_rdata, i_rdata} !== {2'b10, 32'hAAAA, 32'h0}) begin
            errors++;
            $display("FAIL dual_c1_ret: got rv_d/i=%b d=%h i=%h expected 10 0000aaaa 00000000",
                     {d_rvalid, i_rvalid}, d_rdata, i_rdata);
        end
        tick();
        // cycle 2: I read data returns
        i_req = 0; m_gnt = 0; m_rdata = 32'hBBBB;
        #2;
        checks++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata, protocol_err} !== {2'b10, 32'hBBBB, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL dual_c2_ret: got rv_i/d=%b i=%h d=%h err=%b expected 10 0000bbbb 00000000 0",
                     {i_rvalid, d_rvalid}, i_rdata, d_rdata, protocol_err);
        end
        tick();
        m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic test_write_hold();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; m_gnt = 0;
        for (int c = 0; c < 4; c++) begin
            i_req = (c == 1 || c == 3);
            i_addr = 32'h80;
            m_gnt = (c == 3);
            #2;
            checks++;
            if ({m_req, m_we, m_addr, m_wdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL hold_mux c%0d: got req/we=%b addr=%h wdata=%h expected 11 00000040 deadbeef",
                         c, {m_req, m_we}, m_addr, m_wdata);
            end
            checks++;
            if ({d_gnt, i_gnt} !== {(c == 3), 1'b0}) begin
                errors++;
                $display("FAIL hold_gnt c%0d: got gnt_d/i=%b expected %b", c, {d_gnt, i_gnt}, {(c == 3), 1'b0});
            end
            tick();
        end
        d_req = 0; d_we = 0; i_req = 0; m_gnt = 0;
        for (int c = 4; c < 6; c++) begin
            #2;
            checks++;
            if ({i_rvalid, d_rvalid, protocol_err} !== 3'b000) begin
                errors++;
                $display("FAIL hold_noret c%0d: got rv_i/d/err=%b expected 000", c, {i_rvalid, d_rvalid, protocol_err});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_gnt, exp_rv;
        logic [31:0] exp_data;
        for (int c = 0; c < 8; c++) begin
            l3_i_req    = (c < 4);
            l3_i_addr   = 32'h100 + 32'(4 * c);
            l3_m_gnt    = (c < 4);
            l3_m_rvalid = (c >= 3 && c <= 6);
            l3_m_rdata  = l3_m_rvalid ? 32'h1000 + 32'(c) : 32'h0;
            exp_gnt     = (c < 4);
            exp_rv      = (c >= 3 && c <= 6);
            exp_data    = exp_rv ? 32'h1000 + 32'(c) : 32'h0;
            #2;
            checks++;
            if ({l3_i_gnt, l3_i_rvalid, l3_i_rdata, l3_d_rvalid, l3_protocol_err} !==
                {exp_gnt, exp_rv, exp_data, 2'b00}) begin
                errors++;
                $display("FAIL b2b c%0d: got gnt=%b rv=%b data=%h d_rv=%b err=%b expected gnt=%b rv=%b data=%h d_rv=0 err=0",
                         c, l3_i_gnt, l3_i_rvalid, l3_i_rdata, l3_d_rvalid, l3_protocol_err,
                         exp_gnt, exp_rv, exp_data);
            end
            tick();
        end
        l3_i_req = 0; l3_m_gnt = 0; l3_m_rvalid = 0; l3_m_rdata = '0;
    endtask

    task automatic test_stray_rvalid();
        m_rvalid = 1; m_rdata = 32'h5555;
        #2;
        checks++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
            errors++;
            $display("FAIL stray_fwd: got rv_i/d=%b i=%h d=%h expected 00 0 0", {i_rvalid, d_rvalid}, i_rdata, d_rdata);
        end
        tick();
        m_rvalid = 0; m_rdata = '0;
        #2;
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_err: got %b expected 1", protocol_err);
        end
        tick(); tick(); tick();
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_sticky: got %b expected 1", protocol_err);
        end
    endtask

    task automatic test_reset_mid_op();
        // cycle 0: I read accepted on the RD_LAT=3 instance
        l3_i_req = 1; l3_i_addr = 32'h200; l3_m_gnt = 1;
        tick();
        // cycle 1: D write stalls -> locks to D
        l3_i_req = 0; l3_d_req = 1; l3_d_we = 1; l3_d_addr = 32'h44; l3_d_wdata = 32'h99; l3_m_gnt = 0;
        tick();
        checks++;
        if (u_dut3.state !== ARB_HOLD_D) begin
            errors++;
            $display("FAIL midrst_hold: got state=%0d expected %0d", u_dut3.state, ARB_HOLD_D);
        end
        rst = 1;
        #1;
        checks++;
        if ({l3_m_req, l3_m_we, l3_d_gnt, l3_i_gnt, l3_i_rvalid, l3_d_rvalid, l3_protocol_err, l3_m_addr} !== 39'h0) begin
            errors++;
            $display("FAIL midrst_out: got %h expected 0",
                     {l3_m_req, l3_m_we, l3_d_gnt, l3_i_gnt, l3_i_rvalid, l3_d_rvalid, l3_protocol_err, l3_m_addr});
        end
        checks++;
        if (u_dut3.state !== ARB_IDLE || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got state=%0d err=%b expected state=0 err=0", u_dut3.state, protocol_err);
        end
        tick();
        rst = 0;
        l3_d_req = 0; l3_d_we = 0;
        l3_m_rvalid = 1; l3_m_rdata = 32'h7777;
        #2;
        checks++;
        if ({l3_i_rvalid, l3_d_rvalid, l3_i_rdata, l3_d_rdata} !== 66'h0) begin
            errors++;
            $display("FAIL midrst_late: got rv_i/d=%b i=%h d=%h expected 00 0 0",
                     {l3_i_rvalid, l3_d_rvalid}, l3_i_rdata, l3_d_rdata);
        end
        tick();
        l3_m_rvalid = 0; l3_m_rdata = '0;
        #2;
        checks++;
        if (l3_protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_err: got %b expected 0", l3_protocol_err);
        end
        tick();
    endtask

    task automatic test_arbitration();
        logic own_d, prev_d;
        prev_d = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_req = (c < 4); i_addr = 32'h300; d_req = (c < 4); d_we = 0; d_addr = 32'h400;
            m_gnt = (c < 4);
            m_rvalid = (c >= 1); m_rdata = 32'h2000 + 32'(c);
            own_d = RR_EN ? (c % 2 == 0) : 1'b1;
            #2;
            checks++;
            if ({d_gnt, i_gnt} !== ((c < 4) ? {own_d, !own_d} : 2'b00)) begin
                errors++;
                $display("FAIL arb_gnt c%0d: got gnt_d/i=%b expected %b", c, {d_gnt, i_gnt},
                         (c < 4) ? {own_d, !own_d} : 2'b00);
            end
            if (c >= 1) begin
                checks++;
                if ({d_rvalid, i_rvalid} !== {prev_d, !prev_d}) begin
                    errors++;
                    $display("FAIL arb_ret c%0d: got rv_d/i=%b expected %b", c, {d_rvalid, i_rvalid}, {prev_d, !prev_d});
                end
            end
            prev_d = own_d;
            tick();
        end
        idle_inputs();
        #2;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL arb_err: got %b expected 0", protocol_err);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dual_read();
        test_write_hold();
        test_back_to_back();
        test_stray_rvalid();
        test_reset_mid_op();
        test_arbitration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
